// File: rtl/camo_keyed_core_if.sv
// Bus bundle for camo_keyed_core: serial key port, lane data inputs and
// obfuscated state outputs.
`default_nettype none

interface camo_keyed_core_if #(
  parameter int WIDTH = 4
);
  logic             key_in;
  logic             key_load;
  logic             in_valid;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic [WIDTH-1:0] in_d;
  logic [WIDTH-1:0] q1;
  logic [WIDTH-1:0] q2;
  logic [WIDTH-1:0] q3;
  logic             out_valid;
  logic             key_done;

  modport master (
    output key_in, key_load, in_valid, in_a, in_b, in_c, in_d,
    input  q1, q2, q3, out_valid, key_done
  );

  modport slave (
    input  key_in, key_load, in_valid, in_a, in_b, in_c, in_d,
    output q1, q2, q3, out_valid, key_done
  );
endinterface

`default_nettype wire

// File: rtl/camo_keyed_core.sv
// camo_keyed_core: WIDTH-lane NAND/OR/XOR feedback slice whose camo cells take
// their function from a serially loaded key; data is only accepted in RUN.
`default_nettype none

module camo_keyed_core #(
  parameter int WIDTH = 4,
  parameter int CELLS = 2
) (
  input  logic              CLK,
  input  logic              NRST,
  camo_keyed_core_if.slave  bus
);

  localparam int KEYW = 2 * CELLS;
  localparam int CW   = $clog2(KEYW + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(KEYW);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] KEY_LOAD = 2'd1;
  localparam logic [1:0] RUN      = 2'd2;

  logic [1:0]      state;
  logic [KEYW-1:0] key;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] q1_reg, q3_reg, r7;
  logic            out_valid_reg;

  logic [WIDTH-1:0] g, n5, fb, n1, n3, n4;
  logic [KEYW-1:0]  key_shifted;
  logic [CW-1:0]    cnt_inc;
  logic             running;

  assign key_shifted = {bus.key_in, key[KEYW-1:1]};
  assign cnt_inc     = cnt + CW'(1);
  assign running     = (state == RUN);

  // Lane j is wired to cell j mod CELLS; each cell reads its own 2-bit key slice.
  for (genvar j = 0; j < WIDTH; j++) begin : g_lane
    localparam int K = j % CELLS;
    logic [1:0] sel;
    logic       c, d;
    assign sel = key[2*K+1 : 2*K];
    assign c   = bus.in_c[j];
    assign d   = bus.in_d[j];

    always_comb begin
      g[j] = 1'b0;
      case (sel)
        2'b00:   g[j] = ~(c & d);
        2'b01:   g[j] = ~(c | d);
        2'b10:   g[j] = c ^ d;
        default: g[j] = ~(c ^ d);
      endcase
    end

    assign n5[j] = ~(g[j] & bus.in_b[j]);
    assign fb[j] = ~(q3_reg[j] & n5[j]);
    assign n1[j] = fb[j] | bus.in_a[j];
    assign n3[j] = ~(n1[j] & bus.in_b[j]);
    assign n4[j] = ~(n3[j] & g[j]);
  end

  always_ff @(posedge CLK or posedge NRST) begin
    if (NRST) begin
      state         <= IDLE;
      key           <= '0;
      cnt           <= '0;
      q1_reg        <= '0;
      q3_reg        <= '0;
      r7            <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (bus.key_load) begin
            // Starting a load wipes the data path and counts this cycle's bit.
            state  <= KEY_LOAD;
            key    <= key_shifted;
            cnt    <= CW'(1);
            q1_reg <= '0;
            q3_reg <= '0;
            r7     <= '0;
          end else if (running) begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
              q3_reg <= n4;
              r7     <= n5;
              q1_reg <= fb;
            end
          end
        end
        KEY_LOAD: begin
          if (bus.key_load) begin
            key <= key_shifted;
            cnt <= cnt_inc;
            if (cnt_inc == LAST_BIT) begin
              state <= RUN;
            end
          end else begin
            // A short load is discarded entirely.
            state <= IDLE;
            key   <= '0;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.q1        = q1_reg;
  assign bus.q3        = q3_reg;
  assign bus.q2        = running ? (fb & (r7 ^ fb)) : '0;
  assign bus.out_valid = out_valid_reg;
  assign bus.key_done  = running;

endmodule

`default_nettype wire

// File: tb/tb_camo_keyed_core.sv
// Directed self-checking bench for camo_keyed_core (WIDTH=4, CELLS=2).
`default_nettype none

module tb_camo_keyed_core;

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  camo_keyed_core_if #(.WIDTH(4)) bus ();

  camo_keyed_core #(.WIDTH(4), .CELLS(2)) dut (
    .CLK  (clk),
    .NRST (nrst),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_out(input string tag);
    chk({tag, ".q1"}, 32'(bus.q1), 32'h0);
    chk({tag, ".q3"}, 32'(bus.q3), 32'h0);
    chk({tag, ".q2"}, 32'(bus.q2), 32'h0);
    chk({tag, ".ov"}, 32'(bus.out_valid), 32'h0);
    chk({tag, ".kd"}, 32'(bus.key_done), 32'h0);
  endtask

  task automatic set_data(input logic [3:0] a, b, c, d, input logic v);
    bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_d = d; bus.in_valid = v;
  endtask

  // Shift bits[0] first; optional in_valid on the final bit; returns at the
  // negedge after the last shift with key_load dropped.
  task automatic load_key(input logic [3:0] bits, input logic v_last);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.key_load = 1'b1;
      bus.key_in   = bits[i];
      bus.in_valid = (i == 3) ? v_last : 1'b0;
    end
    @(negedge clk);
    bus.key_load = 1'b0;
    bus.key_in   = 1'b0;
  endtask

  task automatic do_reset();
    #1 nrst = 1'b1;
    @(negedge clk);
    nrst = 1'b0;
  endtask

  initial begin
    bus.key_in = 1'b0; bus.key_load = 1'b0;
    set_data(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    #2;
    chk_zero_out("reset");
    @(negedge clk);
    nrst = 1'b0;

    // NAND key, two valid cycles
    load_key(4'b0000, 1'b0);
    chk("nand.key_done", 32'(bus.key_done), 32'h1);
    set_data(4'h0, 4'hF, 4'hF, 4'hF, 1'b1);
    #1 chk("nand.q2_pre", 32'(bus.q2), 32'hF);
    @(posedge clk); #1;
    chk("nand.e1.q3", 32'(bus.q3), 32'hF);
    chk("nand.e1.q1", 32'(bus.q1), 32'hF);
    chk("nand.e1.ov", 32'(bus.out_valid), 32'h1);
    @(posedge clk); #1;
    chk("nand.e2.q3", 32'(bus.q3), 32'hF);
    chk("nand.e2.q1", 32'(bus.q1), 32'h0);
    chk("nand.e2.q2", 32'(bus.q2), 32'h0);

    // Re-key from RUN with key 0101 (both cells NOR)
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.key_load = 1'b1;
      bus.key_in   = (i % 2 == 0) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      if (i == 0) begin
        chk("rekey.q1", 32'(bus.q1), 32'h0);
        chk("rekey.q3", 32'(bus.q3), 32'h0);
        chk("rekey.ov", 32'(bus.out_valid), 32'h0);
      end
      chk($sformatf("rekey.kd%0d", i), 32'(bus.key_done), (i == 3) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    bus.key_load = 1'b0;
    set_data(4'h0, 4'h0, 4'h5, 4'h0, 1'b1);
    @(posedge clk); #1;
    chk("nor.q3", 32'(bus.q3), 32'h5);
    chk("nor.q1", 32'(bus.q1), 32'hF);

    // Asynchronous reset between edges while running
    #2 nrst = 1'b1;
    #1 chk_zero_out("async_rst");
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst.kd", 32'(bus.key_done), 32'h0);
    chk("post_rst.ov", 32'(bus.out_valid), 32'h0);

    // XOR key: bits 0,1,0,1 -> key 1010
    do_reset();
    load_key(4'b1010, 1'b0);
    set_data(4'h0, 4'h0, 4'h5, 4'h0, 1'b1);
    @(posedge clk); #1;
    chk("xor.q3", 32'(bus.q3), 32'hA);
    chk("xor.q1", 32'(bus.q1), 32'hF);

    // Same stimulus with NAND key
    do_reset();
    set_data(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    load_key(4'b0000, 1'b0);
    set_data(4'h0, 4'h0, 4'h5, 4'h0, 1'b1);
    @(posedge clk); #1;
    chk("nand2.q3", 32'(bus.q3), 32'h0);
    chk("nand2.q1", 32'(bus.q1), 32'hF);

    // in_valid high on the final key bit is ignored
    do_reset();
    set_data(4'h0, 4'hF, 4'hF, 4'hF, 1'b0);
    load_key(4'b0000, 1'b1);
    chk("bnd.ov", 32'(bus.out_valid), 32'h0);
    chk("bnd.q1", 32'(bus.q1), 32'h0);
    chk("bnd.kd", 32'(bus.key_done), 32'h1);
    @(posedge clk); #1;
    chk("bnd.next_ov", 32'(bus.out_valid), 32'h1);

    // Aborted load: two bits then key_load low
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.key_load = 1'b1;
      bus.key_in   = 1'b1;
    end
    @(negedge clk);
    bus.key_load = 1'b0;
    @(negedge clk);
    set_data(4'hF, 4'hF, 4'h3, 4'h6, 1'b1);
    @(posedge clk); #1;
    chk_zero_out("abort");
    @(posedge clk); #1;
    chk("abort2.q3", 32'(bus.q3), 32'h0);
    chk("abort2.ov", 32'(bus.out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/camo_keyed_core.md
# camo_keyed_core

Parametrised, key-programmed successor to the single-slice camouflage core. It replicates the NAND/OR/XOR feedback slice across `WIDTH` lanes. Each `CAMO2` cell's function is set by a serially loaded key held in a `CELLS`-entry key register rather than fixed at layout. It sits between the primary inputs and the obfuscated state outputs. No data is processed until a complete key has been loaded.

## Interface
- `WIDTH`, 4, number of data lanes
- `CELLS`, 2, number of independently keyed camo cells; lane j uses cell j mod `CELLS`
- `KEYW`, 2*`CELLS`, key register width (derived, not overridable)
- `CLK`  in  1  single clock, rising edge
- `NRST`  in  1  reset, asynchronous, active-high (asserted = 1)
- `key_in`  in  1  serial key bit
- `key_load`  in  1  key shift enable
- `in_valid`  in  1  data qualifier
- `in_a`, `in_b`, `in_c`, `in_d`  in  `WIDTH` each  lane data inputs
- `q1`, `q3`  out  `WIDTH` each  registered state outputs
- `q2`  out  `WIDTH`  combinational output
- `out_valid`  out  1  registered `in_valid` accepted in RUN
- `key_done`  out  1  high while in RUN

## Operation
- FSM states: IDLE (reset), KEY_LOAD, RUN.
- **Key shift:**
  - On every cycle with `key_load`=1: `key <= {key_in, key[KEYW-1:1]}`, and the bit counter increments.
  - Bits are sent `key[0]` first.
- **Entering KEY_LOAD:** `key_load`=1 in IDLE or RUN moves the FSM to KEY_LOAD. That cycle also captures the first bit and counts it. Entry clears the counter, data registers and `out_valid`.
- **KEY_LOAD exits:**
  - Cycle that shifts bit number `KEYW`: next state RUN.
  - `key_load`=0 before `KEYW` bits have been shifted: abort. Next state IDLE, key cleared to 0.
- **Re-keying from RUN:** `key_load`=1 in RUN starts a fresh load. If `key_load` is held continuously, bit `KEYW`+1 restarts the load.
- **Cell function,** per cell `k`, from `key[2k+1:2k]`: 00 NAND, 01 NOR, 10 XOR, 11 XNOR.
- **Per lane j, combinational:**
  - `g = CAMO_k(in_c[j], in_d[j])`
  - `n5 = ~(g & in_b[j])`
  - `fb = ~(q3[j] & n5)`
  - `n1 = fb | in_a[j]`
  - `n3 = ~(n1 & in_b[j])`
  - `n4 = ~(n3 & g)`
- **Per lane register update** (only when state = RUN and `in_valid` = 1; otherwise hold):
  - `q3 <= n4`
  - `r7 <= n5` (internal)
  - `q1 <= fb`
- **`q2` output:** `q2 = RUN ? fb & (r7 ^ fb) : 0`.
- **`out_valid`:** next value is `RUN & in_valid`.
- `in_valid` is ignored in IDLE and KEY_LOAD, including the cycle in which the last key bit is shifted.

## Timing
- **Reset (`NRST`=1, async):**
  - State IDLE, `key`=0, counter 0.
  - `q1`=`q3`=`r7`=0, `q2`=0, `out_valid`=0, `key_done`=0.
- Reset asserted mid-load or mid-RUN takes effect immediately; the partial key is lost.
- **Key load latency:** `KEYW` cycles of `key_load`=1. `key_done`=1 from the edge after the `KEYW`-th bit.
- **Data latency:** `q1`/`q3`/`out_valid` follow the accepting edge by 1 cycle. `q2` reflects current inputs combinationally.
- Abort and re-key leave `q1`/`q3`=0 until the next accepted RUN cycle.

## Test plan
1. **Reset mid-RUN:** load key 0000, drive `in_valid`=1, assert `NRST` between edges -> all outputs 0 asynchronously; `key_done`=0; IDLE after release.
2. **NAND key:** load bits 0,0,0,0, then a=0, b=F, c=F, d=F, `in_valid`=1 for 2 cycles:
   - Edge 1 -> `q3`=F, `q1`=F, `out_valid`=1.
   - Edge 2 -> `q3`=F, `q1`=0, `q2`=0.
3. **XOR vs NAND key:** from reset, a=0, b=0, c=5, d=0, one valid cycle:
   - Key sent 0,1,0,1 (`key`=1010) -> `q3`=A, `q1`=F.
   - Same stimulus with key 0000 -> `q3`=0, `q1`=F.
4. **Aborted load:** `key_load` high for 2 bits, then low; then `in_valid`=1 with any data -> state IDLE, `key_done`=0, `q1`/`q3`/`out_valid` remain 0.
5. **Re-key from RUN:** after test 2, pulse `key_load` with 4 new bits -> `q1`/`q3` cleared on the first load cycle; `key_done` low for 4 cycles, then high.
6. **Boundary:** `in_valid`=1 during the final key bit -> not accepted; `out_valid` stays 0 on the following edge.
